// File: rtl/eth_stats_counter.sv
// Passive per-port Ethernet stats counter: snoops TX/RX AXI4-Stream handshakes and
// accumulates 64-bit byte, good-frame and bad-frame totals tagged with a 6-bit stats_id.

module eth_stats_dir #(
    parameter int data_bytes = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  srst,
    input  logic                  enable,
    input  logic [data_bytes-1:0] tkeep,
    input  logic                  tvalid,
    input  logic                  tready,
    input  logic                  tlast,
    input  logic                  tuser,
    output logic                  commit,
    output logic                  commit_bad,
    output logic [15:0]           commit_len
);
    // DISCARD swallows the tail of a frame that a soft reset cut short.
    typedef enum logic [1:0] {IDLE, IN_FRAME, DISCARD} state_t;

    state_t      state, state_next;
    logic        counted, counted_next;
    logic [15:0] len, len_next;
    logic [15:0] pop;
    logic [16:0] sum;
    logic [15:0] len_sat;
    logic        beat;

    assign beat = tvalid & tready;

    always_comb begin
        pop = '0;
        for (int i = 0; i < data_bytes; i++) begin
            pop = pop + 16'(tkeep[i]);
        end
    end

    assign sum     = {1'b0, len} + {1'b0, pop};
    assign len_sat = sum[16] ? 16'hFFFF : sum[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            counted <= 1'b0;
            len     <= '0;
        end else begin
            state   <= state_next;
            counted <= counted_next;
            len     <= len_next;
        end
    end

    always_comb begin
        state_next   = state;
        counted_next = counted;
        len_next     = len;
        commit       = 1'b0;
        commit_bad   = tuser;
        commit_len   = len_sat;
        case (state)
            IDLE: begin
                if (beat) begin
                    if (tlast) begin
                        commit     = enable;
                        commit_len = pop;
                    end else begin
                        state_next   = IN_FRAME;
                        counted_next = enable;
                        len_next     = pop;
                    end
                end
            end
            IN_FRAME: begin
                if (beat) begin
                    len_next = len_sat;
                    if (tlast) begin
                        commit     = counted;
                        state_next = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (beat && tlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (srst) begin
            commit       = 1'b0;
            counted_next = 1'b0;
            len_next     = '0;
            if (beat && tlast)
                state_next = IDLE;
            else if (beat || state != IDLE)
                state_next = DISCARD;
            else
                state_next = IDLE;
        end
    end
endmodule

module eth_stats_counter #(
    parameter int data_bytes      = 8,
    parameter bit count_bad_bytes = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  srst,
    input  logic [data_bytes-1:0] tx_tkeep,
    input  logic                  tx_tvalid,
    input  logic                  tx_tready,
    input  logic                  tx_tlast,
    input  logic                  tx_tuser,
    input  logic [data_bytes-1:0] rx_tkeep,
    input  logic                  rx_tvalid,
    input  logic                  rx_tready,
    input  logic                  rx_tlast,
    input  logic                  rx_tuser,
    output logic [5:0]            stats_id,
    output logic [63:0]           tx_bytes,
    output logic [63:0]           tx_good,
    output logic [63:0]           tx_bad,
    output logic [63:0]           rx_bytes,
    output logic [63:0]           rx_good,
    output logic [63:0]           rx_bad
);
    logic        tx_commit, tx_commit_bad, rx_commit, rx_commit_bad;
    logic [15:0] tx_len, rx_len;
    logic        tx_add_bytes, rx_add_bytes;

    eth_stats_dir #(.data_bytes(data_bytes)) u_tx (
        .clk(clk), .rst(rst), .srst(srst), .enable(enable),
        .tkeep(tx_tkeep), .tvalid(tx_tvalid), .tready(tx_tready),
        .tlast(tx_tlast), .tuser(tx_tuser),
        .commit(tx_commit), .commit_bad(tx_commit_bad), .commit_len(tx_len)
    );

    eth_stats_dir #(.data_bytes(data_bytes)) u_rx (
        .clk(clk), .rst(rst), .srst(srst), .enable(enable),
        .tkeep(rx_tkeep), .tvalid(rx_tvalid), .tready(rx_tready),
        .tlast(rx_tlast), .tuser(rx_tuser),
        .commit(rx_commit), .commit_bad(rx_commit_bad), .commit_len(rx_len)
    );

    assign tx_add_bytes = tx_commit && (!tx_commit_bad || count_bad_bytes);
    assign rx_add_bytes = rx_commit && (!rx_commit_bad || count_bad_bytes);

    // Totals and stats_id share one register stage so they always move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stats_id <= '0;
            tx_bytes <= '0;
            tx_good  <= '0;
            tx_bad   <= '0;
            rx_bytes <= '0;
            rx_good  <= '0;
            rx_bad   <= '0;
        end else if (srst) begin
            stats_id <= '0;
            tx_bytes <= '0;
            tx_good  <= '0;
            tx_bad   <= '0;
            rx_bytes <= '0;
            rx_good  <= '0;
            rx_bad   <= '0;
        end else begin
            if (tx_commit || rx_commit) stats_id <= stats_id + 6'd1;
            if (tx_add_bytes)               tx_bytes <= tx_bytes + 64'(tx_len);
            if (tx_commit && !tx_commit_bad) tx_good <= tx_good + 64'd1;
            if (tx_commit && tx_commit_bad)  tx_bad  <= tx_bad + 64'd1;
            if (rx_add_bytes)               rx_bytes <= rx_bytes + 64'(rx_len);
            if (rx_commit && !rx_commit_bad) rx_good <= rx_good + 64'd1;
            if (rx_commit && rx_commit_bad)  rx_bad  <= rx_bad + 64'd1;
        end
    end
endmodule

// File: tb/tb_eth_stats_counter.sv
// Directed bench for eth_stats_counter; a second instance with count_bad_bytes=0
// shares the stimulus so both bad-byte settings are checked in one run.

module tb_eth_stats_counter;
    logic       clk = 1'b0;
    logic       rst, enable, srst;
    logic [7:0] tx_tkeep, rx_tkeep;
    logic       tx_tvalid, tx_tready, tx_tlast, tx_tuser;
    logic       rx_tvalid, rx_tready, rx_tlast, rx_tuser;
    logic [5:0]  stats_id, stats_id0;
    logic [63:0] tx_bytes, tx_good, tx_bad, rx_bytes, rx_good, rx_bad;
    logic [63:0] tx_bytes0, tx_good0, tx_bad0, rx_bytes0, rx_good0, rx_bad0;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    eth_stats_counter #(.data_bytes(8), .count_bad_bytes(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .srst(srst),
        .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
        .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
        .stats_id(stats_id), .tx_bytes(tx_bytes), .tx_good(tx_good), .tx_bad(tx_bad),
        .rx_bytes(rx_bytes), .rx_good(rx_good), .rx_bad(rx_bad)
    );

    eth_stats_counter #(.data_bytes(8), .count_bad_bytes(1'b0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .srst(srst),
        .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
        .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
        .stats_id(stats_id0), .tx_bytes(tx_bytes0), .tx_good(tx_good0), .tx_bad(tx_bad0),
        .rx_bytes(rx_bytes0), .rx_good(rx_good0), .rx_bad(rx_bad0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_tx();
        tx_tvalid = 1'b0; tx_tready = 1'b0; tx_tlast = 1'b0; tx_tuser = 1'b0; tx_tkeep = '0;
    endtask

    task automatic idle_rx();
        rx_tvalid = 1'b0; rx_tready = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0; rx_tkeep = '0;
    endtask

    // Inputs change at negedge; the beat is taken at the following posedge and
    // its commit is visible when the task returns at the next negedge.
    task automatic tx_beat(input logic [7:0] k, input logic l, input logic u);
        tx_tvalid = 1'b1; tx_tready = 1'b1; tx_tkeep = k; tx_tlast = l; tx_tuser = u;
        @(negedge clk);
        idle_tx();
    endtask

    task automatic rx_beat(input logic [7:0] k, input logic l, input logic u);
        rx_tvalid = 1'b1; rx_tready = 1'b1; rx_tkeep = k; rx_tlast = l; rx_tuser = u;
        @(negedge clk);
        idle_rx();
    endtask

    task automatic both_beat(input logic [7:0] k, input logic l);
        tx_tvalid = 1'b1; tx_tready = 1'b1; tx_tkeep = k; tx_tlast = l; tx_tuser = 1'b0;
        rx_tvalid = 1'b1; rx_tready = 1'b1; rx_tkeep = k; rx_tlast = l; rx_tuser = 1'b0;
        @(negedge clk);
        idle_tx();
        idle_rx();
    endtask

    initial begin
        rst = 1'b1; srst = 1'b0; enable = 1'b1;
        idle_tx();
        idle_rx();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset stats_id", 64'(stats_id), 0);
        chk("reset tx_bytes", tx_bytes, 0);
        chk("reset tx_good", tx_good, 0);
        chk("reset tx_bad", tx_bad, 0);
        chk("reset rx_bytes", rx_bytes, 0);
        chk("reset rx_good", rx_good, 0);
        chk("reset rx_bad", rx_bad, 0);

        // 8 full beats + 4-byte last beat = 68 bytes
        for (int i = 0; i < 8; i++) tx_beat(8'hFF, 1'b0, 1'b0);
        chk("tx mid-frame stats_id", 64'(stats_id), 0);
        tx_beat(8'h0F, 1'b1, 1'b0);
        chk("good tx bytes", tx_bytes, 68);
        chk("good tx good", tx_good, 1);
        chk("good tx stats_id", 64'(stats_id), 1);
        chk("good tx rx_bytes", rx_bytes, 0);
        chk("good tx rx_good", rx_good, 0);

        rx_beat(8'h3F, 1'b1, 1'b1);
        chk("bad rx bad", rx_bad, 1);
        chk("bad rx bytes cbb1", rx_bytes, 6);
        chk("bad rx good", rx_good, 0);
        chk("bad rx stats_id", 64'(stats_id), 2);
        chk("bad rx bytes cbb0", rx_bytes0, 0);
        chk("bad rx bad cbb0", rx_bad0, 1);
        chk("cbb0 tx bytes", tx_bytes0, 68);

        // Simultaneous 64-byte good frames on both directions
        for (int i = 0; i < 8; i++) both_beat(8'hFF, i == 7);
        chk("sim tx good", tx_good, 2);
        chk("sim rx good", rx_good, 1);
        chk("sim tx bytes", tx_bytes, 132);
        chk("sim rx bytes", rx_bytes, 70);
        chk("sim stats_id", 64'(stats_id), 3);

        // tvalid without tready is not a beat
        tx_tvalid = 1'b1; tx_tready = 1'b0; tx_tkeep = 8'hFF; tx_tlast = 1'b1;
        @(negedge clk);
        idle_tx();
        @(negedge clk);
        chk("no-handshake tx good", tx_good, 2);

        // Enable low at first beat: frame ignored even though enable rises
        enable = 1'b0;
        tx_beat(8'hFF, 1'b0, 1'b0);
        enable = 1'b1;
        tx_beat(8'hFF, 1'b0, 1'b0);
        tx_beat(8'hFF, 1'b1, 1'b0);
        chk("uncounted tx good", tx_good, 2);
        chk("uncounted tx bytes", tx_bytes, 132);
        chk("uncounted stats_id", 64'(stats_id), 3);

        // Enable high at first beat: counted even though enable drops
        tx_beat(8'h01, 1'b0, 1'b0);
        enable = 1'b0;
        tx_beat(8'h03, 1'b1, 1'b0);
        enable = 1'b1;
        chk("counted tx good", tx_good, 3);
        chk("counted tx bytes", tx_bytes, 135);
        chk("counted stats_id", 64'(stats_id), 4);

        // srst on beat 3 of a 5-beat frame
        tx_beat(8'hFF, 1'b0, 1'b0);
        tx_beat(8'hFF, 1'b0, 1'b0);
        srst = 1'b1;
        tx_beat(8'hFF, 1'b0, 1'b0);
        srst = 1'b0;
        chk("srst stats_id", 64'(stats_id), 0);
        chk("srst tx bytes", tx_bytes, 0);
        chk("srst tx good", tx_good, 0);
        chk("srst rx bytes", rx_bytes, 0);
        chk("srst rx bad", rx_bad, 0);
        tx_beat(8'hFF, 1'b0, 1'b0);
        tx_beat(8'hFF, 1'b1, 1'b0);
        chk("discard tx good", tx_good, 0);
        chk("discard stats_id", 64'(stats_id), 0);
        tx_beat(8'h0F, 1'b1, 1'b0);
        chk("post-srst tx good", tx_good, 1);
        chk("post-srst tx bytes", tx_bytes, 4);
        chk("post-srst stats_id", 64'(stats_id), 1);

        // stats_id wrap over 64 back-to-back single-beat frames
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        for (int i = 0; i < 63; i++) tx_beat(8'h01, 1'b1, 1'b0);
        chk("wrap stats_id 63", 64'(stats_id), 63);
        tx_beat(8'h01, 1'b1, 1'b0);
        chk("wrap stats_id 0", 64'(stats_id), 0);
        chk("wrap tx good", tx_good, 64);
        chk("wrap tx bytes", tx_bytes, 64);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
